wb_merge: RTL and testbench

- Write-back merge stage directly upstream of the register file's single write port.
- Merges two write sources into one registered write per cycle:
  - the in-order MEM/WB pipeline result, always accepted;
  - a long-latency unit's result (multi-cycle divide/multiply), accepted via valid/ready.
- Deferred long-latency writes are held in a small pending buffer.
- Also reports read-address hazards against pending entries so ID can stall.

---
 rtl/wb_merge_pkg.sv | 14 +
 rtl/wb_merge_if.sv | 37 +++
 rtl/wb_pend_fifo.sv | 84 ++++++++
 rtl/wb_merge.sv | 87 ++++++++
 tb/tb_wb_merge.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_merge_pkg.sv
// Shared write-back definitions: register bus widths, reset/write levels and
// the pending-buffer depth used by the merge stage.
package wb_merge_pkg;
  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int WbDepth    = 2;

  localparam logic RstnEnable   = 1'b0;
  localparam logic RstnDisable  = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [RegBus-1:0] ZeroWord = '0;
endpackage

// File: rtl/wb_merge_if.sv
// Write-back merge bus: pipeline write, long-latency handshake, register-file
// write port and ID hazard lookups.
interface wb_merge_if
  import wb_merge_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus
);
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_waddr;
  logic [DATA_W-1:0] pipe_wdata;
  logic              late_valid;
  logic              late_ready;
  logic [ADDR_W-1:0] late_waddr;
  logic [DATA_W-1:0] late_wdata;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic              pend1;
  logic              pend2;

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  late_valid, late_waddr, late_wdata,
    input  raddr1, raddr2,
    output late_ready, we, waddr, wdata, pend1, pend2
  );

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output late_valid, late_waddr, late_wdata,
    output raddr1, raddr2,
    input  late_ready, we, waddr, wdata, pend1, pend2
  );
endinterface

// File: rtl/wb_pend_fifo.sv
// Pending buffer for deferred long-latency writes: in-order storage with
// per-entry valid bits, squash-by-address and two read-address lookups.
module wb_pend_fifo
  import wb_merge_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus,
  parameter int DEPTH  = WbDepth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              sq_en,
  input  logic [ADDR_W-1:0] sq_addr,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              full,
  output logic              empty,
  output logic              head_vld,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              match1,
  output logic              match2
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  cnt_q;

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign head_vld  = vld_q[head_q];
  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];

  // Free slots always carry a cleared valid bit, so lookups need no occupancy mask.
  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i] == raddr1) && (raddr1 != '0)) match1 = 1'b1;
      if (vld_q[i] && (addr_q[i] == raddr2) && (raddr2 != '0)) match2 = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstnEnable) begin
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sq_en && (addr_q[i] == sq_addr)) vld_q[i] <= 1'b0;
      end
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PTR_W'(1);
      end
      if (push) begin
        addr_q[tail_q] <= push_addr;
        data_q[tail_q] <= push_data;
        vld_q[tail_q]  <= 1'b1;
        tail_q         <= tail_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/wb_merge.sv
// Write-back merge: pipeline result first, then the oldest pending late write,
// then a direct bypass of a late write into an empty buffer; one registered write.
module wb_merge
  import wb_merge_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus,
  parameter int DEPTH  = WbDepth
) (
  input logic        clk,
  input logic        rst,
  wb_merge_if.slave  bus
);
  logic              pipe_wr, xfer, late_drop, bypass, push, pop, pop_wr;
  logic              fifo_full, fifo_empty, head_vld;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              match1, match2;
  logic              rst_done_q, we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  assign pipe_wr   = bus.pipe_we && (bus.pipe_waddr != '0);
  assign xfer      = bus.late_valid && bus.late_ready;
  // Writes to r0 and writes already overtaken by a same-cycle pipe write are dropped.
  assign late_drop = (bus.late_waddr == '0) || (pipe_wr && (bus.late_waddr == bus.pipe_waddr));
  assign pop       = !fifo_empty && (!head_vld || !pipe_wr);
  assign pop_wr    = pop && head_vld;
  assign bypass    = !pipe_wr && fifo_empty && xfer && !late_drop;
  assign push      = xfer && !late_drop && !bypass;

  assign bus.late_ready = rst_done_q && !fifo_full;
  assign bus.we         = we_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.pend1      = match1;
  assign bus.pend2      = match2;

  wb_pend_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (bus.late_waddr),
    .push_data (bus.late_wdata),
    .pop       (pop),
    .sq_en     (pipe_wr),
    .sq_addr   (bus.pipe_waddr),
    .raddr1    (bus.raddr1),
    .raddr2    (bus.raddr2),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_vld  (head_vld),
    .head_addr (head_addr),
    .head_data (head_data),
    .match1    (match1),
    .match2    (match2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstnEnable) begin
      rst_done_q <= 1'b0;
      we_q       <= WriteDisable;
      waddr_q    <= '0;
      wdata_q    <= DATA_W'(ZeroWord);
    end else begin
      rst_done_q <= RstnDisable;
      we_q       <= WriteDisable;
      if (pipe_wr) begin
        we_q    <= WriteEnable;
        waddr_q <= bus.pipe_waddr;
        wdata_q <= bus.pipe_wdata;
      end else if (pop_wr) begin
        we_q    <= WriteEnable;
        waddr_q <= head_addr;
        wdata_q <= head_data;
      end else if (bypass) begin
        we_q    <= WriteEnable;
        waddr_q <= bus.late_waddr;
        wdata_q <= bus.late_wdata;
      end
    end
  end
endmodule

// File: tb/tb_wb_merge.sv
// Bench for wb_merge: directed vector table, hand-written reset sequences and
// random traffic checked against a queue-based reference model.
module tb_wb_merge;
  import wb_merge_pkg::*;

  localparam int DEPTH = WbDepth;

  typedef struct {
    logic        pwe;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_rdy;
    logic        e_p1;
    logic        e_p2;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          v;
  } ent_t;

  logic clk;
  logic rst;
  wb_merge_if bus ();

  wb_merge u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  ent_t        q[$];
  bit          m_rst_done;
  bit          m_acc;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  vec_t tab[24];
  vec_t zv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int pwe, input int pa, input int pd, input int lv,
                              input int la, input int ld, input int r1, input int r2,
                              input int e_rdy, input int e_p1, input int e_p2,
                              input int e_we, input int e_wa, input int e_wd);
    vec_t v;
    v.pwe = pwe[0];   v.pa = pa[4:0];   v.pd = pd;
    v.lv  = lv[0];    v.la = la[4:0];   v.ld = ld;
    v.r1  = r1[4:0];  v.r2 = r2[4:0];
    v.e_rdy = e_rdy[0]; v.e_p1 = e_p1[0]; v.e_p2 = e_p2[0];
    v.e_we  = e_we[0];  v.e_wa = e_wa[4:0]; v.e_wd = e_wd;
    return v;
  endfunction

  function automatic bit m_pend(input logic [4:0] ra);
    if (ra == '0) return 1'b0;
    foreach (q[i]) if (q[i].v && q[i].a == ra) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    q.delete();
    m_rst_done = 1'b0;
    m_acc      = 1'b0;
    m_we       = 1'b0;
    m_waddr    = '0;
    m_wdata    = '0;
  endtask

  task automatic drive(input vec_t v);
    bus.pipe_we    = v.pwe;
    bus.pipe_waddr = v.pa;
    bus.pipe_wdata = v.pd;
    bus.late_valid = v.lv;
    bus.late_waddr = v.la;
    bus.late_wdata = v.ld;
    bus.raddr1     = v.r1;
    bus.raddr2     = v.r2;
  endtask

  // One clock: check combinational outputs, advance the model, check the write register.
  task automatic tick(input bit use_tab, input vec_t v);
    bit   rdy, xfer, pwr, drop, was_empty, wrote, byp;
    ent_t e;
    #1;
    rdy = m_rst_done && (q.size() < DEPTH);
    if (use_tab) begin
      chk("late_ready", 32'(bus.late_ready), 32'(v.e_rdy));
      chk("pend1", 32'(bus.pend1), 32'(v.e_p1));
      chk("pend2", 32'(bus.pend2), 32'(v.e_p2));
    end else begin
      chk("late_ready", 32'(bus.late_ready), 32'(rdy));
      chk("pend1", 32'(bus.pend1), 32'(m_pend(bus.raddr1)));
      chk("pend2", 32'(bus.pend2), 32'(m_pend(bus.raddr2)));
    end
    xfer      = bus.late_valid && rdy;
    pwr       = bus.pipe_we && (bus.pipe_waddr != '0);
    drop      = (bus.late_waddr == '0) || (pwr && bus.late_waddr == bus.pipe_waddr);
    was_empty = (q.size() == 0);
    wrote     = 1'b0;
    byp       = 1'b0;
    if (pwr) begin
      m_we = 1'b1; m_waddr = bus.pipe_waddr; m_wdata = bus.pipe_wdata; wrote = 1'b1;
    end
    if (!was_empty && !q[0].v) begin
      void'(q.pop_front());
    end else if (!was_empty && !wrote) begin
      m_we = 1'b1; m_waddr = q[0].a; m_wdata = q[0].d; wrote = 1'b1;
      void'(q.pop_front());
    end else if (was_empty && !wrote && xfer && !drop) begin
      m_we = 1'b1; m_waddr = bus.late_waddr; m_wdata = bus.late_wdata; wrote = 1'b1;
      byp = 1'b1;
    end
    if (!wrote) m_we = 1'b0;
    if (pwr) foreach (q[i]) if (q[i].a == bus.pipe_waddr) q[i].v = 1'b0;
    if (xfer && !drop && !byp) begin
      e.a = bus.late_waddr; e.d = bus.late_wdata; e.v = 1'b1;
      q.push_back(e);
    end
    m_acc = xfer;
    @(posedge clk);
    #1;
    m_rst_done = 1'b1;
    if (use_tab) begin
      chk("we", 32'(bus.we), 32'(v.e_we));
      chk("waddr", 32'(bus.waddr), 32'(v.e_wa));
      chk("wdata", bus.wdata, v.e_wd);
    end else begin
      chk("we", 32'(bus.we), 32'(m_we));
      chk("waddr", 32'(bus.waddr), 32'(m_waddr));
      chk("wdata", bus.wdata, m_wdata);
    end
  endtask

  bit   hold;
  vec_t rv;

  initial begin
    checks = 0;
    errors = 0;
    zv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //       pwe pa pd            lv la ld            r1 r2  rdy p1 p2  we wa wd
    tab[0]  = mk(0, 0, 0,          1, 3, 32'hDEADBEEF, 3, 0,  1, 0, 0,  1, 3, 32'hDEADBEEF);
    tab[1]  = mk(0, 0, 0,          0, 0, 0,            3, 0,  1, 0, 0,  0, 3, 32'hDEADBEEF);
    tab[2]  = mk(1, 1, 32'h101,    1, 5, 32'h55,       5, 0,  1, 0, 0,  1, 1, 32'h101);
    tab[3]  = mk(1, 2, 32'h102,    0, 0, 0,            5, 0,  1, 1, 0,  1, 2, 32'h102);
    tab[4]  = mk(1, 4, 32'h104,    0, 0, 0,            5, 0,  1, 1, 0,  1, 4, 32'h104);
    tab[5]  = mk(0, 0, 0,          0, 0, 0,            5, 0,  1, 1, 0,  1, 5, 32'h55);
    tab[6]  = mk(0, 0, 0,          0, 0, 0,            5, 0,  1, 0, 0,  0, 5, 32'h55);
    tab[7]  = mk(1, 1, 32'h201,    1, 8, 32'h88,       8, 0,  1, 0, 0,  1, 1, 32'h201);
    tab[8]  = mk(1, 2, 32'h202,    1, 9, 32'h99,       8, 9,  1, 1, 0,  1, 2, 32'h202);
    tab[9]  = mk(1, 4, 32'h204,    1, 10, 32'hAA,      8, 9,  0, 1, 1,  1, 4, 32'h204);
    tab[10] = mk(0, 0, 0,          1, 10, 32'hAA,      10, 8, 0, 0, 1,  1, 8, 32'h88);
    tab[11] = mk(0, 0, 0,          1, 10, 32'hAA,      10, 9, 1, 0, 1,  1, 9, 32'h99);
    tab[12] = mk(0, 0, 0,          0, 0, 0,            10, 9, 1, 1, 0,  1, 10, 32'hAA);
    tab[13] = mk(0, 0, 0,          0, 0, 0,            10, 0, 1, 0, 0,  0, 10, 32'hAA);
    tab[14] = mk(1, 1, 32'h301,    1, 7, 32'h11,       7, 0,  1, 0, 0,  1, 1, 32'h301);
    tab[15] = mk(1, 7, 32'h22,     0, 0, 0,            7, 0,  1, 1, 0,  1, 7, 32'h22);
    tab[16] = mk(0, 0, 0,          0, 0, 0,            7, 0,  1, 0, 0,  0, 7, 32'h22);
    tab[17] = mk(0, 0, 0,          0, 0, 0,            7, 0,  1, 0, 0,  0, 7, 32'h22);
    tab[18] = mk(1, 0, 32'h333,    0, 0, 0,            0, 0,  1, 0, 0,  0, 7, 32'h22);
    tab[19] = mk(0, 0, 0,          1, 0, 32'h444,      0, 0,  1, 0, 0,  0, 7, 32'h22);
    tab[20] = mk(0, 0, 0,          1, 6, 32'h66,       0, 6,  1, 0, 0,  1, 6, 32'h66);
    tab[21] = mk(1, 3, 32'h503,    1, 3, 32'h777,      3, 0,  1, 0, 0,  1, 3, 32'h503);
    tab[22] = mk(0, 0, 0,          0, 0, 0,            3, 0,  1, 0, 0,  0, 3, 32'h503);
    tab[23] = mk(1, 0, 32'h999,    1, 5, 32'h5A,       0, 0,  1, 0, 0,  1, 5, 32'h5A);

    // Reset held with a producer already presenting a result.
    rst = RstnEnable;
    m_reset();
    drive(mk(0, 0, 0, 1, 3, 32'h1234, 3, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_waddr", 32'(bus.waddr), 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_late_ready", 32'(bus.late_ready), 32'd0);
    chk("rst_pend1", 32'(bus.pend1), 32'd0);
    rst = RstnDisable;
    drive(zv);
    tick(1'b0, zv);

    foreach (tab[i]) begin
      drive(tab[i]);
      tick(1'b1, tab[i]);
    end

    // Reset with two writes pending: both must vanish without reaching the port.
    drive(mk(1, 1, 32'h601, 1, 12, 32'hC12, 12, 13, 0, 0, 0, 0, 0, 0));
    tick(1'b0, zv);
    drive(mk(1, 2, 32'h602, 1, 13, 32'hC13, 12, 13, 0, 0, 0, 0, 0, 0));
    tick(1'b0, zv);
    drive(mk(0, 0, 0, 0, 0, 0, 12, 13, 0, 0, 0, 0, 0, 0));
    rst = RstnEnable;
    m_reset();
    #1;
    chk("midrst_we", 32'(bus.we), 32'd0);
    chk("midrst_waddr", 32'(bus.waddr), 32'd0);
    chk("midrst_wdata", bus.wdata, 32'd0);
    chk("midrst_late_ready", 32'(bus.late_ready), 32'd0);
    chk("midrst_pend1", 32'(bus.pend1), 32'd0);
    chk("midrst_pend2", 32'(bus.pend2), 32'd0);
    rst = RstnDisable;
    repeat (3) tick(1'b0, zv);

    // Random traffic; the producer holds a refused result until it is taken.
    hold = 1'b0;
    rv   = zv;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        rv.lv = ($urandom_range(0, 3) != 0);
        rv.la = 5'($urandom_range(0, 7));
        rv.ld = $urandom;
      end
      rv.pwe = 1'($urandom_range(0, 1));
      rv.pa  = 5'($urandom_range(0, 7));
      rv.pd  = $urandom;
      rv.r1  = 5'($urandom_range(0, 7));
      rv.r2  = 5'($urandom_range(0, 7));
      drive(rv);
      tick(1'b0, zv);
      hold = rv.lv && !m_acc;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
